// File: rtl/stage0_fetch.sv
// rtl/stage0_fetch.sv - instruction fetch and stage sequencer ahead of the stage-1 operand mux
//
// Owns the program counter. Fetches one 32-bit word per instruction from ROM,
// latches the decoded fields, then steps stages 1..3 with one-hot strobes.
// Later stages can pause the sequence with hold or redirect it with a jump.
//
// Ports:
//   clock, reset        rising-edge clock, asynchronous active-low reset
//   rom_address/read    fetch request towards program ROM (rom_address = pc)
//   rom_ready/value     ROM response; rom_value is sampled only in FETCH
//   mblock_s1, vr_source    stage-1 source select and address/constant
//   vw_target, mblock_s3    write-back target and destination select
//   alu_op                  ALU operation
//   stage_s1/s2/s3          one-hot stage strobes
//   jump_en, jump_address   redirect, honoured only on the releasing S3 cycle
//   hold                    keeps the sequencer in S3 while high
//   pc                      address of the current instruction
//   fault                   sticky illegal-instruction flag
module stage0_fetch #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clock,
  input  logic        reset,
  output logic [15:0] rom_address,
  output logic        rom_read,
  input  logic        rom_ready,
  input  logic [31:0] rom_value,
  output logic [1:0]  mblock_s1,
  output logic [7:0]  vr_source,
  output logic [7:0]  vw_target,
  output logic [1:0]  mblock_s3,
  output logic [3:0]  alu_op,
  output logic        stage_s1,
  output logic        stage_s2,
  output logic        stage_s3,
  input  logic        jump_en,
  input  logic [15:0] jump_address,
  input  logic        hold,
  output logic [15:0] pc,
  output logic        fault
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    S1    = 3'd2,
    S2    = 3'd3,
    S3    = 3'd4,
    FAULT = 3'd5
  } state_t;

  state_t state, next_state;

  // Instruction word bits that carry no field, and the jump alignment bits.
  logic unused_bits;
  assign unused_bits = ^{rom_value[23:16], jump_address[1:0]};

  logic fetch_accept;
  logic s3_release;
  assign fetch_accept = (state == FETCH) && rom_ready;
  assign s3_release   = (state == S3) && !hold;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    rom_read   = 1'b0;
    stage_s1   = 1'b0;
    stage_s2   = 1'b0;
    stage_s3   = 1'b0;
    fault      = 1'b0;
    case (state)
      IDLE: next_state = FETCH;
      FETCH: begin
        rom_read = 1'b1;
        if (rom_ready) begin
          // Stage-1 select 2'b01 is reserved: stop rather than execute it.
          next_state = (rom_value[25:24] == 2'b01) ? FAULT : S1;
        end
      end
      S1: begin
        stage_s1   = 1'b1;
        next_state = S2;
      end
      S2: begin
        stage_s2   = 1'b1;
        next_state = S3;
      end
      S3: begin
        stage_s3 = 1'b1;
        if (!hold) begin
          next_state = FETCH;
        end
      end
      FAULT: fault = 1'b1;
      default: next_state = IDLE;
    endcase
  end

  // pc only moves on the edge that leaves S3, so it is already the new
  // fetch address in the first FETCH cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc <= RESET_PC;
    end else if (s3_release) begin
      if (jump_en) begin
        pc <= {jump_address[15:2], 2'b00};
      end else begin
        pc <= pc + 16'd4;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      alu_op    <= 4'h0;
      mblock_s3 <= 2'b00;
      mblock_s1 <= 2'b00;
      vw_target <= 8'h00;
      vr_source <= 8'h00;
    end else if (fetch_accept) begin
      alu_op    <= rom_value[31:28];
      mblock_s3 <= rom_value[27:26];
      mblock_s1 <= rom_value[25:24];
      vw_target <= rom_value[15:8];
      vr_source <= rom_value[7:0];
    end
  end

  assign rom_address = pc;

endmodule

// File: tb/tb_stage0_fetch.sv
// tb/tb_stage0_fetch.sv - directed self-checking bench for stage0_fetch
module tb_stage0_fetch;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] rom_address;
  logic        rom_read;
  logic        rom_ready = 1'b0;
  logic [31:0] rom_value = 32'h0;
  logic [1:0]  mblock_s1;
  logic [7:0]  vr_source;
  logic [7:0]  vw_target;
  logic [1:0]  mblock_s3;
  logic [3:0]  alu_op;
  logic        stage_s1, stage_s2, stage_s3;
  logic        jump_en = 1'b0;
  logic [15:0] jump_address = 16'h0;
  logic        hold = 1'b0;
  logic [15:0] pc;
  logic        fault;

  int n_cmp = 0;
  int n_err = 0;

  stage0_fetch dut (
    .clock(clock), .reset(reset),
    .rom_address(rom_address), .rom_read(rom_read),
    .rom_ready(rom_ready), .rom_value(rom_value),
    .mblock_s1(mblock_s1), .vr_source(vr_source), .vw_target(vw_target),
    .mblock_s3(mblock_s3), .alu_op(alu_op),
    .stage_s1(stage_s1), .stage_s2(stage_s2), .stage_s3(stage_s3),
    .jump_en(jump_en), .jump_address(jump_address), .hold(hold),
    .pc(pc), .fault(fault)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled at the falling edge.
  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic check_strobes(input string tag, input logic [2:0] exp);
    check(tag, {29'h0, stage_s1, stage_s2, stage_s3}, {29'h0, exp});
  endtask

  task automatic check_fields(input string tag, input logic [31:0] instr);
    check({tag, "_mblock_s1"}, {30'h0, mblock_s1}, {30'h0, instr[25:24]});
    check({tag, "_vr_source"}, {24'h0, vr_source}, {24'h0, instr[7:0]});
    check({tag, "_vw_target"}, {24'h0, vw_target}, {24'h0, instr[15:8]});
    check({tag, "_mblock_s3"}, {30'h0, mblock_s3}, {30'h0, instr[27:26]});
    check({tag, "_alu_op"},    {28'h0, alu_op},    {28'h0, instr[31:28]});
  endtask

  initial begin
    @(negedge clock);
    step();
    // Reset state
    check("rst_rom_read", {31'h0, rom_read}, 32'h0);
    check("rst_pc", {16'h0, pc}, 32'h0);
    check("rst_fault", {31'h0, fault}, 32'h0);
    check_strobes("rst_strobes", 3'b000);
    check_fields("rst", 32'h0);

    // Release: one IDLE cycle, then FETCH
    reset = 1'b1;
    #1;
    check("idle_rom_read", {31'h0, rom_read}, 32'h0);
    @(negedge clock);
    step();
    check("fetch0_rom_read", {31'h0, rom_read}, 32'h1);
    check("fetch0_addr", {16'h0, rom_address}, 32'h0);

    // Instruction 1, zero wait; jump pulse in S1 must be ignored
    rom_ready = 1'b1;
    rom_value = 32'h1200_2A05;
    step();
    rom_ready = 1'b0;
    rom_value = 32'hDEAD_BEEF;
    check_strobes("i1_s1", 3'b100);
    check_fields("i1", 32'h1200_2A05);
    check("i1_s1_rom_read", {31'h0, rom_read}, 32'h0);
    jump_en = 1'b1;
    jump_address = 16'h0103;
    step();
    jump_en = 1'b0;
    check_strobes("i1_s2", 3'b010);
    step();
    check_strobes("i1_s3", 3'b001);
    check("i1_s3_pc", {16'h0, pc}, 32'h0);
    step();
    check("fetch1_rom_read", {31'h0, rom_read}, 32'h1);
    check("fetch1_addr", {16'h0, rom_address}, 32'h4);
    check_strobes("fetch1_strobes", 3'b000);

    // Instruction 2 with 3 wait cycles; fields hold old values until ready
    rom_value = 32'hA7C4_1122;
    for (int i = 0; i < 3; i++) begin
      check("wait_rom_read", {31'h0, rom_read}, 32'h1);
      check("wait_vr_source", {24'h0, vr_source}, 32'h05);
      check_strobes("wait_strobes", 3'b000);
      step();
    end
    check("wait_last_rom_read", {31'h0, rom_read}, 32'h1);
    rom_ready = 1'b1;
    step();
    rom_ready = 1'b0;
    check_strobes("i2_s1", 3'b100);
    check_fields("i2", 32'hA7C4_1122);
    step();
    step();
    // Hold for 5 cycles in S3 with jump_en toggling, release with a jump
    for (int i = 0; i < 5; i++) begin
      check_strobes("hold_s3", 3'b001);
      hold = 1'b1;
      jump_en = (i % 2 == 0);
      jump_address = 16'h5550;
      step();
    end
    check_strobes("hold_release_s3", 3'b001);
    hold = 1'b0;
    jump_en = 1'b1;
    jump_address = 16'h0103;
    step();
    jump_en = 1'b0;
    check("jump_addr", {16'h0, rom_address}, 32'h0100);
    check_strobes("jump_fetch_strobes", 3'b000);
    check_fields("i2_kept", 32'hA7C4_1122);

    // Instruction 3 jumps to 16'hFFFC
    rom_ready = 1'b1;
    rom_value = 32'h0000_0000;
    step();
    rom_ready = 1'b0;
    step();
    step();
    jump_en = 1'b1;
    jump_address = 16'hFFFE;
    step();
    jump_en = 1'b0;
    check("top_addr", {16'h0, rom_address}, 32'hFFFC);

    // Instruction 4 falls through and wraps to 0
    rom_ready = 1'b1;
    rom_value = 32'h3000_0001;
    step();
    rom_ready = 1'b0;
    step();
    step();
    step();
    check("wrap_addr", {16'h0, rom_address}, 32'h0000);
    check("wrap_pc", {16'h0, pc}, 32'h0000);

    // Reserved stage-1 select faults and stays there
    rom_ready = 1'b1;
    rom_value = 32'h0100_0000;
    step();
    check("fault_set", {31'h0, fault}, 32'h1);
    check("fault_rom_read", {31'h0, rom_read}, 32'h0);
    check_strobes("fault_strobes", 3'b000);
    jump_en = 1'b1;
    jump_address = 16'h0200;
    for (int i = 0; i < 3; i++) step();
    jump_en = 1'b0;
    rom_ready = 1'b0;
    check("fault_sticky", {31'h0, fault}, 32'h1);
    check("fault_pc", {16'h0, pc}, 32'h0000);
    check_strobes("fault_sticky_strobes", 3'b000);

    // Reset clears the fault; then reset mid-FETCH at pc 4 abandons the fetch
    reset = 1'b0;
    #1;
    check("fault_cleared", {31'h0, fault}, 32'h0);
    @(negedge clock);
    reset = 1'b1;
    step();
    check("restart_addr", {16'h0, rom_address}, 32'h0000);
    check("restart_rom_read", {31'h0, rom_read}, 32'h1);
    rom_ready = 1'b1;
    rom_value = 32'h2000_0000;
    step();
    rom_ready = 1'b0;
    step();
    step();
    step();
    check("mid_fetch_addr", {16'h0, rom_address}, 32'h0004);
    step();
    reset = 1'b0;
    #1;
    check("mid_rst_rom_read", {31'h0, rom_read}, 32'h0);
    check("mid_rst_pc", {16'h0, pc}, 32'h0000);
    check("mid_rst_alu_op", {28'h0, alu_op}, 32'h0);
    @(negedge clock);
    reset = 1'b1;
    step();
    check("mid_rst_refetch", {31'h0, rom_read}, 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
